// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point multiplier back end:
// rounding-mode encoding, exponent bias and limit, and the canonical
// infinity / max-finite magnitudes of the default binary32 format.
package fpu_pkg;

    localparam int FPU_EXP_W   = 8;
    localparam int FPU_MANT_W  = 23;
    localparam int FPU_BIAS    = (1 << (FPU_EXP_W - 1)) - 1;
    localparam int FPU_EXP_MAX = (1 << FPU_EXP_W) - 1;

    // Magnitudes exclude the sign bit; the sign is prepended at pack time.
    localparam logic [FPU_EXP_W+FPU_MANT_W-1:0] FPU_INF_MAG =
        {{FPU_EXP_W{1'b1}}, {FPU_MANT_W{1'b0}}};
    localparam logic [FPU_EXP_W+FPU_MANT_W-1:0] FPU_MAXFIN_MAG =
        {{(FPU_EXP_W-1){1'b1}}, 1'b0, {FPU_MANT_W{1'b1}}};

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_e;

endpackage

// File: rtl/fpu_round_incr.sv
// Rounding increment decision: given the mode, result sign and the
// lsb/guard/sticky bits of a normalized significand, decide whether the
// truncated fraction must be incremented by one ulp.
module fpu_round_incr
    import fpu_pkg::*;
(
    input  rmode_e i_mode,
    input  logic   i_sign,
    input  logic   i_lsb,
    input  logic   i_guard,
    input  logic   i_sticky,
    output logic   o_incr
);

    // Directed modes only round away from zero when the discarded bits are nonzero
    // and the direction agrees with the sign; nearest-even breaks ties on the lsb.
    always_comb begin
        o_incr = 1'b0;
        case (i_mode)
            RM_RNE:  o_incr = i_guard && (i_sticky || i_lsb);
            RM_RTZ:  o_incr = 1'b0;
            RM_RUP:  o_incr = !i_sign && (i_guard || i_sticky);
            RM_RDN:  o_incr = i_sign && (i_guard || i_sticky);
            default: o_incr = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_mul_round.sv
// Normalize/round/pack back end of a floating-point multiplier.
// Two-stage valid/ready pipeline: S1 normalizes the raw significand product
// and extracts guard/sticky, S2 rounds, detects overflow/underflow and packs.
// Format constants come from fpu_pkg, so EXP_W/MANT_W must match that format.
// Build option: define FPU_ROUND_MODES_EN to honour all four rounding modes;
// without it rmode is masked to zero and round-to-nearest-even is always used.
module fpu_mul_round
    import fpu_pkg::*;
#(
    parameter int EXP_W  = FPU_EXP_W,
    parameter int MANT_W = FPU_MANT_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W+1:0]        exp_in,
    input  logic [2*MANT_W+1:0]     mant_in,
    input  logic [1:0]              rmode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    localparam int PW  = 2*MANT_W + 2;
    localparam int MSB = PW - 1;
    localparam int EW  = EXP_W + 3;

    localparam logic signed [EW-1:0] EXP_MAX_S  = EW'(FPU_EXP_MAX);
    localparam logic signed [EW-1:0] EXP_ZERO_S = '0;

`ifdef FPU_ROUND_MODES_EN
    localparam logic [1:0] RMODE_MASK = 2'b11;
`else
    localparam logic [1:0] RMODE_MASK = 2'b00;
`endif

    logic                   w_s1Adv;
    logic                   w_s2Adv;
    logic                   w_top;
    logic [MANT_W-1:0]      w_s1Frac;
    logic                   w_s1Guard;
    logic                   w_s1Sticky;
    logic signed [EW-1:0]   w_s1Exp;

    logic                   r_s1Valid;
    logic                   r_s1Sign;
    logic signed [EW-1:0]   r_s1Exp;
    logic [MANT_W-1:0]      r_s1Frac;
    logic                   r_s1Guard;
    logic                   r_s1Sticky;
    rmode_e                 r_s1Mode;

    logic                   w_incr;
    logic                   w_carry;
    logic [MANT_W-1:0]      w_fracRnd;
    logic signed [EW-1:0]   w_expFin;
    logic                   w_ovf;
    logic                   w_unf;
    logic [EXP_W+MANT_W-1:0] w_ovfMag;
    logic [EXP_W+MANT_W:0]  w_packed;
    logic                   w_inexact;

    logic                   r_outValid;
    logic [EXP_W+MANT_W:0]  r_result;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   r_inexact;

    assign w_s2Adv  = out_ready || !r_outValid;
    assign w_s1Adv  = w_s2Adv || !r_s1Valid;
    assign in_ready = w_s1Adv;

    // Normalize: a product in [2,4) drops one more bit and bumps the exponent.
    always_comb begin
        w_top = mant_in[MSB];
        if (w_top) begin
            w_s1Frac   = mant_in[MSB-1:MANT_W+1];
            w_s1Guard  = mant_in[MANT_W];
            w_s1Sticky = |mant_in[MANT_W-1:0];
        end else begin
            w_s1Frac   = mant_in[MSB-2:MANT_W];
            w_s1Guard  = mant_in[MANT_W-1];
            w_s1Sticky = |mant_in[MANT_W-2:0];
        end
        w_s1Exp = {exp_in[EXP_W+1], exp_in} + EW'(w_top);
    end

    // Stage-1 register: captures the normalized operand whenever S1 may advance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1Valid  <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1Exp    <= '0;
            r_s1Frac   <= '0;
            r_s1Guard  <= 1'b0;
            r_s1Sticky <= 1'b0;
            r_s1Mode   <= RM_RNE;
        end else if (w_s1Adv) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Sign   <= sign_in;
                r_s1Exp    <= w_s1Exp;
                r_s1Frac   <= w_s1Frac;
                r_s1Guard  <= w_s1Guard;
                r_s1Sticky <= w_s1Sticky;
                r_s1Mode   <= rmode_e'(rmode & RMODE_MASK);
            end
        end
    end

    fpu_round_incr u_roundIncr (
        .i_mode   (r_s1Mode),
        .i_sign   (r_s1Sign),
        .i_lsb    (r_s1Frac[0]),
        .i_guard  (r_s1Guard),
        .i_sticky (r_s1Sticky),
        .o_incr   (w_incr)
    );

    // The integer bit is always one, so a carry out of the fraction means the
    // significand wrapped to 1.000..0 and the exponent must absorb it.
    assign {w_carry, w_fracRnd} = {1'b0, r_s1Frac} + (MANT_W+1)'(w_incr);
    assign w_expFin = r_s1Exp + EW'(w_carry);
    assign w_ovf    = (w_expFin >= EXP_MAX_S);
    assign w_unf    = (w_expFin <= EXP_ZERO_S);

    // Pack the rounded value, substituting the mode-dependent overflow value or a signed zero.
    always_comb begin
        w_ovfMag = FPU_INF_MAG;
        case (r_s1Mode)
            RM_RNE:  w_ovfMag = FPU_INF_MAG;
            RM_RTZ:  w_ovfMag = FPU_MAXFIN_MAG;
            RM_RUP:  w_ovfMag = r_s1Sign ? FPU_MAXFIN_MAG : FPU_INF_MAG;
            RM_RDN:  w_ovfMag = r_s1Sign ? FPU_INF_MAG : FPU_MAXFIN_MAG;
            default: w_ovfMag = FPU_INF_MAG;
        endcase
        w_packed = {r_s1Sign, w_expFin[EXP_W-1:0], w_fracRnd};
        if (w_ovf) begin
            w_packed = {r_s1Sign, w_ovfMag};
        end else if (w_unf) begin
            w_packed = {r_s1Sign, {(EXP_W+MANT_W){1'b0}}};
        end
        w_inexact = r_s1Guard || r_s1Sticky || w_ovf || w_unf;
    end

    // Output register: holds the result steady while the consumer stalls.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_outValid  <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (w_s2Adv) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_result    <= w_packed;
                r_overflow  <= w_ovf;
                r_underflow <= w_unf;
                r_inexact   <= w_inexact;
            end
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_fpu_mul_round.sv
// Bench for fpu_mul_round: directed products with hand-computed results,
// pushed into a scoreboard on acceptance and checked by an output monitor.
module tb_fpu_mul_round;
    import fpu_pkg::*;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int RW     = 1 + EXP_W + MANT_W;

    localparam logic [9:0] E127 = 10'(FPU_BIAS);

`ifdef FPU_ROUND_MODES_EN
    localparam logic [31:0] RTZ_OVF    = 32'h7F7FFFFF;
    localparam logic [31:0] RDN_OVF    = 32'h7F7FFFFF;
    localparam logic [31:0] RUP_POS    = 32'h3F800001;
    localparam logic [31:0] RDN_NEG    = 32'hBF800001;
`else
    localparam logic [31:0] RTZ_OVF    = 32'h7F800000;
    localparam logic [31:0] RDN_OVF    = 32'h7F800000;
    localparam logic [31:0] RUP_POS    = 32'h3F800000;
    localparam logic [31:0] RDN_NEG    = 32'hBF800000;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           sign_in = 1'b0;
    logic [9:0]     exp_in = '0;
    logic [47:0]    mant_in = '0;
    logic [1:0]     rmode = 2'b00;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [RW-1:0]  result;
    logic           overflow;
    logic           underflow;
    logic           inexact;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } sb_t;

    sb_t sbQueue[$];
    int  testCount = 0;
    int  failCount = 0;

    fpu_mul_round #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .rmode     (rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        testCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one product and record its expected response once it is accepted.
    task automatic applyStimulus(input string tag, input logic s, input logic [9:0] e,
                                 input logic [47:0] m, input rmode_e rm, input logic [31:0] er,
                                 input logic eo, input logic eu, input logic ei);
        int waitCnt;
        sb_t entry;
        waitCnt = 0;
        @(negedge CLK);
        sign_in  = s;
        exp_in   = e;
        mant_in  = m;
        rmode    = rm;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waitCnt < 50) begin
            @(negedge CLK);
            #1;
            waitCnt++;
        end
        if (!in_ready) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL accept_timeout %s: in_ready stuck at 0, expected 1", tag);
            in_valid = 1'b0;
        end else begin
            @(posedge CLK);
            entry.tag = tag;
            entry.res = er;
            entry.ovf = eo;
            entry.unf = eu;
            entry.inx = ei;
            sbQueue.push_back(entry);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        @(negedge CLK);
        in_valid = 1'b0;
        while (sbQueue.size() != 0 && c < 100) begin
            @(negedge CLK);
            c++;
        end
        if (sbQueue.size() != 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sbQueue.size());
        end
    endtask

    // Monitor: every cycle the output is valid it must match the oldest expectation.
    always @(negedge CLK) begin
        #1;
        if (RST && out_valid) begin
            if (sbQueue.size() == 0) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL unexpected_output: got 0x%0h with no result expected", result);
            end else begin
                checkOutput(sbQueue[0].tag, 64'({result, overflow, underflow, inexact}),
                            64'({sbQueue[0].res, sbQueue[0].ovf, sbQueue[0].unf, sbQueue[0].inx}));
                if (out_ready) begin
                    void'(sbQueue.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_result", 64'(result), 64'(0));
        checkOutput("rst_flags", 64'({overflow, underflow, inexact}), 64'(0));
        @(negedge CLK);
        RST = 1'b1;

        // Latency: result appears on the second edge after acceptance.
        applyStimulus("one", 1'b0, E127, 48'h400000000000, RM_RNE, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        checkOutput("lat_stage1", 64'(out_valid), 64'(0));
        @(negedge CLK);
        #1;
        checkOutput("lat_stage2", 64'(out_valid), 64'(1));
        drain();

        // Directed rounding, normalization and exception vectors, back to back.
        applyStimulus("tie_even",  1'b0, E127, 48'h400000400000, RM_RNE, 32'h3F800000, 1'b0, 1'b0, 1'b1);
        applyStimulus("tie_odd",   1'b0, E127, 48'h400000C00000, RM_RNE, 32'h3F800002, 1'b0, 1'b0, 1'b1);
        applyStimulus("carry_out", 1'b0, E127, 48'h7FFFFFC00000, RM_RNE, 32'h40000000, 1'b0, 1'b0, 1'b1);
        applyStimulus("msb_tie",   1'b0, E127, 48'h800000800000, RM_RNE, 32'h40000000, 1'b0, 1'b0, 1'b1);
        applyStimulus("neg_one",   1'b1, E127, 48'h400000000000, RM_RNE, 32'hBF800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("ovf_rne",   1'b0, 10'd254, 48'h800000000000, RM_RNE, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        applyStimulus("ovf_rtz",   1'b0, 10'd254, 48'h800000000000, RM_RTZ, RTZ_OVF, 1'b1, 1'b0, 1'b1);
        applyStimulus("ovf_rdn",   1'b0, 10'd254, 48'h800000000000, RM_RDN, RDN_OVF, 1'b1, 1'b0, 1'b1);
        applyStimulus("ovf_carry", 1'b0, 10'd254, 48'h7FFFFFC00000, RM_RNE, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        applyStimulus("max_exp",   1'b0, 10'd254, 48'h400000000000, RM_RNE, 32'h7F000000, 1'b0, 1'b0, 1'b0);
        applyStimulus("rup_pos",   1'b0, E127, 48'h400000000001, RM_RUP, RUP_POS, 1'b0, 1'b0, 1'b1);
        applyStimulus("rdn_neg",   1'b1, E127, 48'h400000000001, RM_RDN, RDN_NEG, 1'b0, 1'b0, 1'b1);
        applyStimulus("unf_zero",  1'b0, 10'd0, 48'h400000000000, RM_RNE, 32'h00000000, 1'b0, 1'b1, 1'b1);
        applyStimulus("min_norm",  1'b0, 10'd1, 48'h400000000000, RM_RNE, 32'h00800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("msb_min",   1'b0, 10'd0, 48'h800000000000, RM_RNE, 32'h00800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("unf_neg",   1'b1, 10'h3FB, 48'h400000000000, RM_RNE, 32'h80000000, 1'b0, 1'b1, 1'b1);
        drain();

        // Backpressure: two accepts fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        applyStimulus("strm0", 1'b0, E127, 48'h400000000000, RM_RNE, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("strm1", 1'b0, E127, 48'h400000400000, RM_RNE, 32'h3F800000, 1'b0, 1'b0, 1'b1);
        fork
            begin
                applyStimulus("strm2", 1'b0, E127, 48'h400000C00000, RM_RNE, 32'h3F800002, 1'b0, 1'b0, 1'b1);
                applyStimulus("strm3", 1'b0, E127, 48'h7FFFFFC00000, RM_RNE, 32'h40000000, 1'b0, 1'b0, 1'b1);
            end
            begin
                @(negedge CLK);
                #1;
                checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
                repeat (3) @(negedge CLK);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two products in flight: both must vanish.
        out_ready = 1'b0;
        applyStimulus("flight0", 1'b0, E127, 48'h400000000000, RM_RNE, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("flight1", 1'b1, E127, 48'h400000000000, RM_RNE, 32'hBF800000, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        RST = 1'b0;
        #1;
        checkOutput("rstfly_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rstfly_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rstfly_result", 64'(result), 64'(0));
        sbQueue.delete();
        @(negedge CLK);
        RST = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            #1;
            checkOutput("no_stale", 64'(out_valid), 64'(0));
        end

        applyStimulus("after_rst", 1'b0, E127, 48'h400000000000, RM_RNE, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
